// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared grant/state encoding and AXI response codes for the memory arbiter,
// the LSU and the memory bridge.
package axi_lite_mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    // The grant value is the arbiter state register itself.
    typedef enum logic [1:0] {
        GNT_NONE   = 2'b00,
        GNT_IFU_RD = 2'b01,
        GNT_LSU_RD = 2'b10,
        GNT_LSU_WR = 2'b11
    } grant_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Pending transaction requests, as seen by the arbitration FSM.
    typedef struct packed {
        logic ifu_rd;
        logic lsu_rd;
        logic lsu_wr;
    } req_t;

endpackage

// File: rtl/axi_lite_arb_sel.sv
// Grant FSM: LSU has fixed priority, IFU wins once STARVE_LIMIT LSU grants went by while it waited.
// New grant one cycle after a request is seen in IDLE; holds until the slave response handshakes.
module axi_lite_arb_sel
    import axi_lite_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic   clk,
    input  logic   rst,
    input  req_t   req,
    input  logic   rd_done,
    input  logic   wr_done,
    output grant_e grant
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    grant_e           state_q;
    grant_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             starved;

    assign starved = req.ifu_rd && (cnt_q >= LIMIT);
    assign grant   = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GNT_NONE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            GNT_NONE: begin
                if (req.lsu_wr) begin
                    state_d = GNT_LSU_WR;
                end else if (req.lsu_rd && !starved) begin
                    state_d = GNT_LSU_RD;
                end else if (req.ifu_rd) begin
                    state_d = GNT_IFU_RD;
                end
                // Counter only tracks LSU grants taken while IFU is actually waiting.
                if (!req.ifu_rd || state_d == GNT_IFU_RD) begin
                    cnt_d = '0;
                end else if ((state_d == GNT_LSU_RD || state_d == GNT_LSU_WR) && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            GNT_IFU_RD, GNT_LSU_RD: begin
                if (rd_done) begin
                    state_d = GNT_NONE;
                end
            end
            GNT_LSU_WR: begin
                if (wr_done) begin
                    state_d = GNT_NONE;
                end
            end
            default: state_d = GNT_NONE;
        endcase
    end

    a_ifu_grant_needs_req: assert property (@(posedge clk) disable iff (rst)
        (state_q == GNT_IFU_RD && $past(state_q) == GNT_NONE) |-> $past(req.ifu_rd));

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI4-Lite slave between IFU (read) and LSU (read/write), one whole transaction at a time.
// Requests reach the slave one cycle after being seen in IDLE; non-granted masters see ready=0 and must hold.
module axi_lite_mem_arbiter
    import axi_lite_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    // IFU read master
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    // LSU read/write master
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    output logic [1:0]        lsu_bresp,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,
    // Shared slave
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_arvalid,
    input  logic              s_arready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    input  logic              s_rvalid,
    output logic              s_rready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    output logic              s_wvalid,
    input  logic              s_wready,
    input  logic [1:0]        s_bresp,
    input  logic              s_bvalid,
    output logic              s_bready,
    output logic [1:0]        grant
);

    grant_e gnt;
    req_t   req;
    logic   ifu_sel;
    logic   lsu_rd_sel;
    logic   lsu_wr_sel;

    assign req = '{ifu_rd: ifu_arvalid, lsu_rd: lsu_arvalid, lsu_wr: lsu_awvalid};

    axi_lite_arb_sel #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_sel (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .rd_done (s_rvalid & s_rready),
        .wr_done (s_bvalid & s_bready),
        .grant   (gnt)
    );

    assign grant      = gnt;
    assign ifu_sel    = (gnt == GNT_IFU_RD);
    assign lsu_rd_sel = (gnt == GNT_LSU_RD);
    assign lsu_wr_sel = (gnt == GNT_LSU_WR);

    // Read path: payloads are shared, every valid/ready is gated by the owner.
    assign s_araddr    = lsu_rd_sel ? lsu_araddr : ifu_araddr;
    assign s_arvalid   = (ifu_sel & ifu_arvalid) | (lsu_rd_sel & lsu_arvalid);
    assign s_rready    = (ifu_sel & ifu_rready) | (lsu_rd_sel & lsu_rready);
    assign ifu_arready = ifu_sel & s_arready;
    assign lsu_arready = lsu_rd_sel & s_arready;
    assign ifu_rvalid  = ifu_sel & s_rvalid;
    assign lsu_rvalid  = lsu_rd_sel & s_rvalid;
    assign ifu_rdata   = s_rdata;
    assign ifu_rresp   = s_rresp;
    assign lsu_rdata   = s_rdata;
    assign lsu_rresp   = s_rresp;

    // Write path: AW and W handshake independently while the LSU owns the slave.
    assign s_awaddr    = lsu_awaddr;
    assign s_awvalid   = lsu_wr_sel & lsu_awvalid;
    assign s_wdata     = lsu_wdata;
    assign s_wstrb     = lsu_wstrb;
    assign s_wvalid    = lsu_wr_sel & lsu_wvalid;
    assign s_bready    = lsu_wr_sel & lsu_bready;
    assign lsu_awready = lsu_wr_sel & s_awready;
    assign lsu_wready  = lsu_wr_sel & s_wready;
    assign lsu_bvalid  = lsu_wr_sel & s_bvalid;
    assign lsu_bresp   = s_bresp;

    a_wr_valid_only_in_wr: assert property (@(posedge clk) disable iff (rst)
        (s_awvalid || s_wvalid) |-> (gnt == GNT_LSU_WR));

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench for axi_lite_mem_arbiter: arbitration table plus multi-cycle sequences.
module tb_axi_lite_mem_arbiter;
    import axi_lite_mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr, lsu_araddr, lsu_awaddr, lsu_wdata, s_rdata;
    logic        ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic        lsu_awvalid, lsu_wvalid, lsu_bready;
    logic [3:0]  lsu_wstrb;
    logic        s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
    logic [1:0]  s_rresp, s_bresp;
    logic        ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid;
    logic        lsu_awready, lsu_wready, lsu_bvalid;
    logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
    logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp, grant;
    logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready;
    logic [3:0]  s_wstrb;

    int checks = 0;
    int errors = 0;
    int both_rdy = 0;

    typedef struct {
        logic       ifu_v;
        logic       lsu_rv;
        logic       lsu_wv;
        logic [1:0] gnt;
        logic [6:0] hs;  // {ifu_arready, lsu_arready, lsu_awready, lsu_wready, s_arvalid, s_awvalid, s_wvalid}
    } arb_vec_t;

    arb_vec_t vecs [8];

    axi_lite_mem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb), .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready),
        .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ifu_arready && lsu_arready) both_rdy++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ifu_araddr = '0; ifu_arvalid = 0; ifu_rready = 0;
        lsu_araddr = '0; lsu_arvalid = 0; lsu_rready = 0;
        lsu_awaddr = '0; lsu_awvalid = 0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_wvalid = 0; lsu_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Serves a granted read: immediate AR accept, data lat cycles later; ends back in IDLE.
    task automatic serve_read(input logic is_ifu, input logic [31:0] addr, input int lat,
                              input logic [31:0] data, input logic [1:0] resp, input string tag);
        s_arready = 1;
        #1;
        chk({tag, " arready"}, {30'b0, ifu_arready, lsu_arready}, is_ifu ? 32'd2 : 32'd1);
        chk({tag, " s_araddr"}, s_araddr, addr);
        tick();
        s_arready = 0;
        if (is_ifu) ifu_arvalid = 0;
        else lsu_arvalid = 0;
        repeat (lat) tick();
        s_rvalid = 1; s_rdata = data; s_rresp = resp;
        ifu_rready = 1; lsu_rready = 1;
        #1;
        chk({tag, " rvalid"}, {30'b0, ifu_rvalid, lsu_rvalid}, is_ifu ? 32'd2 : 32'd1);
        chk({tag, " rdata"}, is_ifu ? ifu_rdata : lsu_rdata, data);
        chk({tag, " rresp"}, {30'b0, is_ifu ? ifu_rresp : lsu_rresp}, {30'b0, resp});
        tick();
        s_rvalid = 0; ifu_rready = 0; lsu_rready = 0;
        chk({tag, " grant idle"}, {30'b0, grant}, 32'd0);
    endtask

    initial begin
        int lsu_grants;
        bit got_ifu;

        vecs[0] = '{0, 0, 0, GNT_NONE,   7'b0000_000};
        vecs[1] = '{1, 0, 0, GNT_IFU_RD, 7'b1000_100};
        vecs[2] = '{0, 1, 0, GNT_LSU_RD, 7'b0100_100};
        vecs[3] = '{0, 0, 1, GNT_LSU_WR, 7'b0011_011};
        vecs[4] = '{1, 1, 0, GNT_LSU_RD, 7'b0100_100};
        vecs[5] = '{0, 1, 1, GNT_LSU_WR, 7'b0011_011};
        vecs[6] = '{1, 1, 1, GNT_LSU_WR, 7'b0011_011};
        vecs[7] = '{1, 0, 1, GNT_LSU_WR, 7'b0011_011};

        // Reset state: every decoded valid/ready low even with slave-side stimulus present
        clear_inputs();
        rst = 1;
        tick();
        tick();
        rst = 0;
        s_arready = 1; s_awready = 1; s_wready = 1; s_rvalid = 1; s_bvalid = 1;
        ifu_rready = 1; lsu_rready = 1; lsu_bready = 1;
        #1;
        chk("reset grant", {30'b0, grant}, 32'd0);
        chk("reset outputs",
            {19'b0, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready, ifu_arready, lsu_arready,
             lsu_awready, lsu_wready, ifu_rvalid, lsu_rvalid, lsu_bvalid, 1'b0}, 32'd0);
        clear_inputs();

        // Arbitration table, each vector from IDLE with a cleared starvation counter
        for (int i = 0; i < 8; i++) begin
            ifu_arvalid = vecs[i].ifu_v; lsu_arvalid = vecs[i].lsu_rv;
            lsu_awvalid = vecs[i].lsu_wv; lsu_wvalid = vecs[i].lsu_wv;
            s_arready = 1; s_awready = 1; s_wready = 1;
            tick();
            chk($sformatf("vec%0d grant", i), {30'b0, grant}, {30'b0, vecs[i].gnt});
            chk($sformatf("vec%0d handshake", i),
                {25'b0, ifu_arready, lsu_arready, lsu_awready, lsu_wready, s_arvalid, s_awvalid, s_wvalid},
                {25'b0, vecs[i].hs});
            clear_inputs();
            if (vecs[i].gnt == GNT_IFU_RD || vecs[i].gnt == GNT_LSU_RD) begin
                s_rvalid = 1; ifu_rready = 1; lsu_rready = 1;
            end else if (vecs[i].gnt == GNT_LSU_WR) begin
                s_bvalid = 1; lsu_bready = 1;
            end
            tick();
            clear_inputs();
            chk($sformatf("vec%0d back to idle", i), {30'b0, grant}, 32'd0);
            tick();
        end

        // IFU-only read, data two cycles after the AR handshake
        do_reset();
        ifu_araddr = 32'h8000_0000; ifu_arvalid = 1;
        #1;
        chk("ifu no bypass", {31'b0, s_arvalid}, 32'd0);
        tick();
        chk("ifu grant", {30'b0, grant}, 32'd1);
        serve_read(1, 32'h8000_0000, 2, 32'h0000_0413, RESP_OKAY, "ifu_only");

        // Simultaneous reads: LSU first, then IFU
        do_reset();
        ifu_araddr = 32'h8000_0004; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_1000; lsu_arvalid = 1;
        tick();
        chk("simul first grant", {30'b0, grant}, 32'd2);
        serve_read(0, 32'h8000_1000, 1, 32'h1111_2222, RESP_OKAY, "simul_lsu");
        chk("simul gap idle", {30'b0, grant}, 32'd0);
        tick();
        chk("simul second grant", {30'b0, grant}, 32'd1);
        serve_read(1, 32'h8000_0004, 1, 32'h3333_4444, RESP_OKAY, "simul_ifu");

        // LSU write, W accepted two cycles before AW
        do_reset();
        lsu_awaddr = 32'h8000_2000; lsu_awvalid = 1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'hF; lsu_wvalid = 1;
        tick();
        chk("wr grant", {30'b0, grant}, 32'd3);
        chk("wr s_awaddr", s_awaddr, 32'h8000_2000);
        chk("wr s_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("wr s_wstrb", {28'b0, s_wstrb}, 32'hF);
        chk("wr s_arvalid", {31'b0, s_arvalid}, 32'd0);
        s_wready = 1;
        #1;
        chk("wr w first", {28'b0, lsu_wready, lsu_awready, s_wvalid, s_awvalid}, 32'b1011);
        tick();
        lsu_wvalid = 0; s_wready = 0;
        tick();
        s_awready = 1;
        #1;
        chk("wr aw second", {28'b0, lsu_wready, lsu_awready, s_wvalid, s_awvalid}, 32'b0101);
        tick();
        lsu_awvalid = 0; s_awready = 0;
        chk("wr still granted", {30'b0, grant}, 32'd3);
        s_bvalid = 1; s_bresp = RESP_OKAY; lsu_bready = 1;
        #1;
        chk("wr bvalid", {29'b0, lsu_bvalid, s_bready, 1'b0}, 32'b110);
        chk("wr bresp", {30'b0, lsu_bresp}, 32'd0);
        tick();
        s_bvalid = 0; lsu_bready = 0;
        chk("wr grant idle", {30'b0, grant}, 32'd0);

        // Starvation: continuous LSU reads with IFU waiting
        do_reset();
        ifu_araddr = 32'h8000_0008; ifu_arvalid = 1;
        lsu_araddr = 32'h8000_3000; lsu_arvalid = 1;
        lsu_grants = 0;
        got_ifu = 0;
        for (int k = 0; k < 8 && !got_ifu; k++) begin
            tick();
            if (grant == GNT_LSU_RD) begin
                serve_read(0, 32'h8000_3000, 0, 32'h0000_1000 + k, RESP_OKAY, $sformatf("starve_lsu%0d", k));
                lsu_grants++;
                lsu_arvalid = 1;
            end else if (grant == GNT_IFU_RD) begin
                got_ifu = 1;
                serve_read(1, 32'h8000_0008, 0, 32'hCAFE_0001, RESP_OKAY, "starve_ifu");
            end
        end
        chk("starve lsu grants", lsu_grants, 32'd4);
        chk("starve ifu served", {31'b0, got_ifu}, 32'd1);
        ifu_arvalid = 1;
        tick();
        chk("starve counter cleared", {30'b0, grant}, 32'd2);

        // Error passthrough on an LSU read
        do_reset();
        lsu_araddr = 32'h8000_4000; lsu_arvalid = 1;
        tick();
        chk("err grant", {30'b0, grant}, 32'd2);
        serve_read(0, 32'h8000_4000, 1, 32'hBAD0_0BAD, RESP_SLVERR, "err_slverr");

        // Reset after AW handshake, before the write response
        do_reset();
        lsu_awaddr = 32'h8000_5000; lsu_awvalid = 1;
        lsu_wdata = 32'h0123_4567; lsu_wstrb = 4'h3; lsu_wvalid = 1;
        tick();
        s_awready = 1; s_wready = 1;
        tick();
        s_awready = 0; s_wready = 0;
        lsu_bready = 1;
        rst = 1;
        tick();
        rst = 0;
        s_bvalid = 1;
        #1;
        chk("rst grant", {30'b0, grant}, 32'd0);
        chk("rst aw/w valids", {30'b0, s_awvalid, s_wvalid}, 32'd0);
        chk("rst no stray bvalid", {30'b0, lsu_bvalid, s_bready}, 32'd0);
        clear_inputs();
        tick();

        chk("arready exclusive", both_rdy, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_arbiter.md
Name: axi_lite_mem_arbiter

Overview:
- Shares one AXI4-Lite memory slave between the instruction fetch unit master (IFU, read-only) and the load/store unit master (LSU, read+write).
- Sits between the IFU/LSU AXI master ports and the SRAM/memory bridge.
- Grants one whole transaction at a time: address phase through response. At most one transaction is outstanding on the slave side.
- LSU has fixed priority. A starvation counter guarantees IFU forward progress.

Parameters:
- STARVE_LIMIT, 4: consecutive LSU grants allowed while IFU is waiting; the next grant then goes to IFU.
- CNT_W, 3: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ifu_araddr/ifu_arvalid  in  32/1  IFU read-address channel.
- ifu_arready  out  1  IFU read-address accept.
- ifu_rdata/ifu_rresp/ifu_rvalid  out  32/2/1  IFU read-data channel.
- ifu_rready  in  1  IFU read-data accept.
- lsu_araddr/lsu_arvalid  in  32/1  LSU read-address channel.
- lsu_arready  out  1  LSU read-address accept.
- lsu_rdata/lsu_rresp/lsu_rvalid  out  32/2/1  LSU read-data channel.
- lsu_rready  in  1  LSU read-data accept.
- lsu_awaddr/lsu_awvalid  in  32/1  LSU write-address channel.
- lsu_awready  out  1  LSU write-address accept.
- lsu_wdata/lsu_wstrb/lsu_wvalid  in  32/4/1  LSU write-data channel.
- lsu_wready  out  1  LSU write-data accept.
- lsu_bresp/lsu_bvalid  out  2/1  LSU write response.
- lsu_bready  in  1  LSU write-response accept.
- s_araddr/s_arvalid, s_arready  out/out, in  32/1, 1  slave read-address channel.
- s_rdata/s_rresp/s_rvalid, s_rready  in, out  32/2/1, 1  slave read-data channel.
- s_awaddr/s_awvalid, s_awready  out/out, in  32/1, 1  slave write-address channel.
- s_wdata/s_wstrb/s_wvalid, s_wready  out, in  32/4/1, 1  slave write-data channel.
- s_bresp/s_bvalid, s_bready  in, out  2/1, 1  slave write-response channel.
- grant  out  2  current owner, registered: 00 none, 01 IFU read, 10 LSU read, 11 LSU write.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, grant=00, starvation counter=0. Every slave-side valid/ready output and every master-side ready/valid output is 0 on the first cycle after reset (all are decoded from state).
- FSM states and encoding: IDLE(00), IFU_RD(01), LSU_RD(10), LSU_WR(11). The grant output equals the state register.
- IDLE arbitration, evaluated on each clk edge:
  - If lsu_awvalid=1 → LSU_WR.
  - Else if lsu_arvalid=1 and (ifu_arvalid=0 or cnt<STARVE_LIMIT) → LSU_RD.
  - Else if ifu_arvalid=1 → IFU_RD.
  - Else stay in IDLE.
- Starvation override: when cnt≥STARVE_LIMIT and ifu_arvalid=1, IFU_RD wins over LSU_RD. LSU_WR still wins.
- Starvation counter:
  - Increments (saturating) on each LSU grant while ifu_arvalid=1.
  - Clears on an IFU grant, or on any IDLE cycle with ifu_arvalid=0.
- Grant latency: a request first seen in IDLE is forwarded to the slave one cycle later. No combinational path from any master valid to any slave valid.
- IFU_RD:
  - s_ar* and s_r* are combinationally connected to ifu_ar*/ifu_r*.
  - All LSU readies and LSU rvalid/bvalid are 0. Slave aw/w valids are 0.
  - Exit to IDLE on the cycle s_rvalid&s_rready=1.
- LSU_RD: same as IFU_RD with the LSU read channels in place of the IFU ones.
- LSU_WR:
  - s_aw*, s_w*, s_b* are connected to the lsu_aw*/lsu_w*/lsu_b* channels. AW and W handshake independently, in any order, as the slave dictates.
  - Exit to IDLE on s_bvalid&s_bready=1.
- Non-granted masters: they see ready=0 and response valid=0. They must hold their valid and payload stable (AXI rule); the arbiter does not latch their requests.
- rresp/bresp pass through unmodified. SLVERR and DECERR end the transaction like OKAY.
- Back-to-back transactions: there is always at least one IDLE cycle between transactions (no bypass).
- Reset during an active transaction: the FSM returns to IDLE and slave valids drop in the next cycle. The slave and masters are reset by the same rst.
- Assertions:
  - grant is never 01 while ifu_arvalid was low at grant time.
  - s_awvalid and s_wvalid are only asserted in LSU_WR.

Decomposition:
- Shared package: state/grant encoding constants (GNT_NONE, GNT_IFU_RD, GNT_LSU_RD, GNT_LSU_WR) and AXI resp codes (OKAY=00, SLVERR=10, DECERR=11). These are reused by the LSU and the memory bridge.
- One natural sub-module, axi_lite_arb_sel: the registered FSM plus starvation counter. It outputs grant only.
- The top level is the combinational channel muxing keyed on grant.

Test Plan:
- IFU-only read: ifu_arvalid=1, araddr=0x8000_0000, slave returns 0x0000_0413 two cycles after ar handshake → grant=01 one cycle after request; ifu_rdata=0x0000_0413 with rresp=00; grant=00 the cycle after the r handshake.
- Simultaneous reads: IFU reads 0x8000_0004, LSU reads 0x8000_1000 in the same cycle → LSU served first (grant=10), IFU served next (grant=01); lsu_arready and ifu_arready are never high together.
- LSU write with W before AW: wdata=0xDEAD_BEEF, wstrb=0xF, addr=0x8000_2000, slave raises wready 2 cycles before awready → both handshakes complete; bresp=00 reaches the LSU; grant returns to 00 after b handshake.
- Starvation: LSU issues continuous reads while ifu_arvalid=1, STARVE_LIMIT=4 → exactly 4 LSU_RD grants, then IFU_RD; counter reads 0 afterwards.
- Error passthrough: slave returns rresp=10 on an LSU read → lsu_rresp=10; FSM returns to IDLE normally.
- Reset mid-write: assert rst for one cycle after AW handshake, before bvalid → grant=00; s_awvalid=s_wvalid=0 next cycle; no stray bvalid reaches the LSU.
